// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate data cache, one word per line; DATA_CACHE_PERF_EN adds hit/miss counters.
// Latency: hits complete in the request cycle; misses take 1 + writeback wait + refill wait + 1 cycles.
// Backpressure: requester holds ls_read/ls_write until ls_hit; memory side holds its request until mem_ready.
module data_cache #(
    parameter int XLEN = 32,
    parameter int SETS = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ls_read,
    input  logic            ls_write,
    input  logic [XLEN-1:0] ls_address,
    input  logic [XLEN-1:0] ls_wdata,
    output logic [XLEN-1:0] ls_rdata,
    output logic            ls_hit,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready
`ifdef DATA_CACHE_PERF_EN
    ,
    output logic [31:0]     perf_hits,
    output logic [31:0]     perf_misses
`endif
);
    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = XLEN - INDEX_W - 2;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, DONE} state_t;

    state_t              state_q, state_d;
    logic [XLEN-3:0]     req_q, req_d;
    logic [SETS-1:0]     valid_q, valid_d;
    logic [SETS-1:0]     dirty_q, dirty_d;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [TAG_W-1:0]    tag_d  [SETS];
    logic [XLEN-1:0]     data_q [SETS];
    logic [XLEN-1:0]     data_d [SETS];

    logic [INDEX_W-1:0]  in_idx, req_idx;
    logic [TAG_W-1:0]    in_tag, req_tag;
    logic                req_any, idle_hit, idle_miss;
    logic                unused_ok;

    assign in_idx    = ls_address[INDEX_W+1:2];
    assign in_tag    = ls_address[XLEN-1:INDEX_W+2];
    assign req_idx   = req_q[INDEX_W-1:0];
    assign req_tag   = req_q[XLEN-3:INDEX_W];
    assign req_any   = ls_read | ls_write;
    assign unused_ok = ^ls_address[1:0];

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        ls_hit      = 1'b0;
        ls_rdata    = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        idle_hit    = 1'b0;
        idle_miss   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    if (valid_q[in_idx] && (tag_q[in_idx] == in_tag)) begin
                        idle_hit = 1'b1;
                        ls_hit   = 1'b1;
                        // A simultaneous read+write is a write.
                        if (ls_write) begin
                            data_d[in_idx]  = ls_wdata;
                            dirty_d[in_idx] = 1'b1;
                        end else begin
                            ls_rdata = data_q[in_idx];
                        end
                    end else begin
                        idle_miss = 1'b1;
                        req_d     = ls_address[XLEN-1:2];
                        state_d   = (valid_q[in_idx] && dirty_q[in_idx]) ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                mem_write   = 1'b1;
                mem_address = {tag_q[req_idx], req_idx, 2'b00};
                mem_wdata   = data_q[req_idx];
                if (mem_ready) begin
                    dirty_d[req_idx] = 1'b0;
                    state_d          = REFILL;
                end
            end
            REFILL: begin
                mem_read    = 1'b1;
                mem_address = {req_q, 2'b00};
                if (mem_ready) begin
                    data_d[req_idx]  = mem_rdata;
                    tag_d[req_idx]   = req_tag;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    state_d          = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                // A request abandoned during the miss gets no response here.
                if (req_any) begin
                    ls_hit = 1'b1;
                    if (ls_write) begin
                        data_d[req_idx]  = ls_wdata;
                        dirty_d[req_idx] = 1'b1;
                    end else begin
                        ls_rdata = data_q[req_idx];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            ls_hit      = 1'b0;
            ls_rdata    = '0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            mem_address = '0;
            mem_wdata   = '0;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

`ifdef DATA_CACHE_PERF_EN
    logic [31:0] perf_hits_q, perf_hits_d;
    logic [31:0] perf_misses_q, perf_misses_d;

    always_comb begin
        perf_hits_d   = perf_hits_q + {31'b0, idle_hit};
        perf_misses_d = perf_misses_q + {31'b0, idle_miss};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
        end else begin
            perf_hits_q   <= perf_hits_d;
            perf_misses_q <= perf_misses_d;
        end
    end

    assign perf_hits   = perf_hits_q;
    assign perf_misses = perf_misses_q;
`else
    logic unused_perf;
    assign unused_perf = idle_hit ^ idle_miss;
`endif

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Acts as the responder for the load/store execution unit's cache bus and as the initiator on the memory bus.
- Serves word-wide reads and writes.
- Misses are handled by a small FSM that writes back the dirty victim, refills the line from memory, then completes the request.

Parameters:
XLEN, 32, data/address width in bits
SETS, 16, number of lines (power of two, >=2); one XLEN word per line
INDEX_W, $clog2(SETS), index width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ls_read  in  1  load request; held by requester until ls_hit
ls_write  in  1  store request; held by requester until ls_hit
ls_address  in  XLEN  byte address; bits [1:0] ignored (word access)
ls_wdata  in  XLEN  store data (full word)
ls_rdata  out  XLEN  load data, valid when ls_hit
ls_hit  out  1  request completes this cycle
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_address  out  XLEN  word-aligned memory address ([1:0]=0)
mem_wdata  out  XLEN  write-back data
mem_rdata  in  XLEN  refill data, valid with mem_ready
mem_ready  in  1  memory completes current request this cycle

Behaviour:
- Address split: offset=[1:0], index=[INDEX_W+1:2], tag=[XLEN-1:INDEX_W+2].
- Per line: valid bit, dirty bit, tag, data word.
- Request priority: if ls_read and ls_write are both high, treat as a write; ls_read is ignored.
- FSM states: IDLE, WRITEBACK, REFILL, DONE.
- IDLE:
  - Hit (valid && tag match) is combinational.
  - Read hit: ls_hit=1, ls_rdata=line data in the same cycle (0-cycle latency).
  - Write hit: ls_hit=1; data and dirty=1 are written at the clock edge.
  - Miss with victim valid&&dirty: go to WRITEBACK. Otherwise go to REFILL.
- WRITEBACK:
  - Drive mem_write=1, mem_address={victim tag,index,2'b00}, mem_wdata=victim data.
  - On mem_ready: clear dirty, go to REFILL.
- REFILL:
  - Drive mem_read=1, mem_address={req tag,index,2'b00}.
  - On mem_ready: store mem_rdata, set valid=1, dirty=0, update tag, go to DONE.
- DONE:
  - Request now hits. Respond exactly as IDLE does (ls_hit=1, read data or write+dirty), then go to IDLE.
  - Miss latency = 1 + writeback wait + refill wait + 1 cycles. Minimum is 3 cycles with mem_ready tied high and a clean victim.
- Request dropped mid-miss (ls_read/ls_write low in REFILL or WRITEBACK): the memory transaction still completes and the line is filled; DONE asserts no ls_hit and returns to IDLE.
- Address change while waiting is illegal; the cache uses the address captured on the IDLE miss edge.
- mem_read and mem_write are never high together. Memory outputs hold stable until mem_ready.
- ls_hit=0 whenever no request is present; ls_rdata is 0 when ls_hit=0.
- Reset:
  - Clears all valid and dirty bits; FSM goes to IDLE.
  - ls_hit=0, ls_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0.
  - Reset during WRITEBACK/REFILL aborts the transaction (dirty data discarded). Outputs are low in the cycle after reset.

Optional Feature:
- DATA_CACHE_PERF_EN defined:
  - Adds outputs perf_hits and perf_misses (32 bits each, wrapping).
  - perf_hits increments on each IDLE-state ls_hit. perf_misses increments on each IDLE-to-WRITEBACK/REFILL transition.
  - Both clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- After reset, ls_read=1 addr 0x0000_0040; memory returns 0xDEAD_BEEF with mem_ready 1 cycle after request -> mem_read addr 0x40, no mem_write, ls_hit=1 with ls_rdata=0xDEAD_BEEF in DONE, then IDLE.
- Repeat read 0x40 -> ls_hit=1 same cycle, ls_rdata=0xDEAD_BEEF, mem_read stays 0.
- Write 0x40 data 0x1234_5678 (hit), then read 0x440 (same index, SETS=16) -> mem_write addr 0x40 data 0x1234_5678 first, then mem_read addr 0x440.
- Write miss to 0x80, memory returns 0x0, mem_ready delayed 3 cycles -> outputs stable while waiting; ls_hit in DONE; subsequent read 0x80 hits with 0x0000_00AA when wdata was 0xAA.
- Assert reset in REFILL -> next cycle mem_read=0, ls_hit=0; read to the previously filled 0x40 misses.
- ls_read and ls_write both high, addr 0x40, wdata 0x5 -> treated as write; later read returns 0x5.
